// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state encoding, widths and helpers for the ROM port arbiter
package mips_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam int WORD_W            = 32;
  localparam int ADDR_W            = 32;
  localparam int ROM_DEPTH_DEFAULT = 256;

  // Counter only ever holds WAIT_CYCLES-1 down to 0.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick with its own last-grant register
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_update,
  output logic [1:0] o_winner
);

  logic r_last_grant;

  always_comb begin
    o_winner = 2'b00;
    if (i_req0 && i_req1) begin
      o_winner = r_last_grant ? 2'b01 : 2'b10;
    end else if (i_req0) begin
      o_winner = 2'b01;
    end else if (i_req1) begin
      o_winner = 2'b10;
    end
  end

  // Resetting to port 1 makes port 0 win the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
    end else if (i_update && (o_winner != 2'b00)) begin
      r_last_grant <= o_winner[1];
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - round-robin sharing of one combinational ROM between fetch and load ports
// Optional out-of-range check enabled by ROM_ARB_BOUNDS_CHECK_EN.
module rom_port_arbiter
  import mips_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ROM_DEPTH   = ROM_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [WORD_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [WORD_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_read_en,
  output logic              rom_ce,
  input  logic [WORD_W-1:0] rom_data,
  output logic              busy
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_port;
  logic [ADDR_W-1:0] r_addr;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [WORD_W-1:0] r_rdata0;
  logic [WORD_W-1:0] r_rdata1;
  logic [1:0]        w_winner;
  logic              w_idle;
  logic              w_access;
  logic              w_start;
  logic              w_done;
  logic              w_rom_on;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [WORD_W-1:0] w_rsp_data;

  rr_arb2 u_rr_arb2 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req0   (req0),
    .i_req1   (req1),
    .i_update (w_idle),
    .o_winner (w_winner)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_access   = (r_state == ST_ACCESS);
  assign w_start    = w_idle && (w_winner != 2'b00);
  assign w_done     = w_access && (r_cnt == '0);
  assign w_sel_addr = w_winner[1] ? addr1 : addr0;

`ifdef ROM_ARB_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(ROM_DEPTH);

  logic r_oor;
  logic r_err0;
  logic r_err1;

  // Out-of-range transactions keep the ROM disabled but keep normal timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oor  <= 1'b0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_err0 <= w_done && !r_port && r_oor;
      r_err1 <= w_done && r_port && r_oor;
      if (w_start) begin
        r_oor <= (w_sel_addr >= L_DEPTH);
      end else if (w_done) begin
        r_oor <= 1'b0;
      end
    end
  end

  assign w_rom_on   = w_access && !r_oor;
  assign w_rsp_data = r_oor ? '0 : rom_data;
  assign err0       = r_err0;
  assign err1       = r_err1;
`else
  logic w_unused_depth;

  assign w_unused_depth = |ROM_DEPTH;
  assign w_rom_on       = w_access;
  assign w_rsp_data     = rom_data;
  assign err0           = 1'b0;
  assign err1           = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next_state = ST_ACCESS;
      ST_ACCESS: if (r_cnt == '0) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_port    <= 1'b0;
      r_addr    <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_gnt0    <= w_start && w_winner[0];
      r_gnt1    <= w_start && w_winner[1];
      r_rvalid0 <= w_done && !r_port;
      r_rvalid1 <= w_done && r_port;
      if (w_start) begin
        r_port <= w_winner[1];
        r_addr <= w_sel_addr;
        r_cnt  <= CNT_W'(WAIT_CYCLES - 1);
      end else if (w_done) begin
        r_addr <= '0;
      end else if (w_access) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done && !r_port) r_rdata0 <= w_rsp_data;
      if (w_done && r_port)  r_rdata1 <= w_rsp_data;
    end
  end

  // Address register is cleared on completion, so the ROM sees zeros outside ACCESS.
  assign rom_address = r_addr;
  assign rom_ce      = w_rom_on;
  assign rom_read_en = w_rom_on;
  assign busy        = w_access;
  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign rvalid0     = r_rvalid0;
  assign rvalid1     = r_rvalid1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - scoreboard bench for rom_port_arbiter at WAIT_CYCLES 1, 3 and 4
// Bounds expectations follow ROM_ARB_BOUNDS_CHECK_EN.
module tb_rom_port_arbiter;

  localparam int N = 3;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0;
  logic        req1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic        gnt0        [N];
  logic        gnt1        [N];
  logic        rvalid0     [N];
  logic        rvalid1     [N];
  logic        err0        [N];
  logic        err1        [N];
  logic        rom_read_en [N];
  logic        rom_ce      [N];
  logic        busy        [N];
  logic [31:0] rdata0      [N];
  logic [31:0] rdata1      [N];
  logic [31:0] rom_address [N];
  logic [31:0] rom_data    [N];

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Never returns zero: byte 2 and byte 3 cannot both be zero.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[7:0] ^ 8'h5A, ~a[7:0], a[15:8] + 8'h3C, a[7:0] + 8'h11};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    rom_port_arbiter #(.WAIT_CYCLES(WC), .ROM_DEPTH(64)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req0        (req0),
      .addr0       (addr0),
      .gnt0        (gnt0[g]),
      .rvalid0     (rvalid0[g]),
      .rdata0      (rdata0[g]),
      .err0        (err0[g]),
      .req1        (req1),
      .addr1       (addr1),
      .gnt1        (gnt1[g]),
      .rvalid1     (rvalid1[g]),
      .rdata1      (rdata1[g]),
      .err1        (err1[g]),
      .rom_address (rom_address[g]),
      .rom_read_en (rom_read_en[g]),
      .rom_ce      (rom_ce[g]),
      .rom_data    (rom_data[g]),
      .busy        (busy[g])
    );
    assign rom_data[g] = rom_fn(rom_address[g]);
  end

  task automatic push_exp(input logic port, input logic [31:0] data, input logic err);
    exp_t e;
    e.port = port;
    e.data = data;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1] || busy[2]) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 30) begin
      errors++;
      $display("FAIL wait_idle: busy still high after %0d cycles, required idle", n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    addr0 = '0;
    addr1 = '0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({gnt0[i], gnt1[i], rvalid0[i], rvalid1[i], err0[i], err1[i], rom_ce[i], rom_read_en[i], busy[i]} !== 9'b0 ||
          rom_address[i] !== 32'd0 || rdata0[i] !== 32'd0 || rdata1[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: ctl=%b addr=%h rd0=%h rd1=%h, required all 0", i,
                 {gnt0[i], gnt1[i], rvalid0[i], rvalid1[i], err0[i], err1[i], rom_ce[i], rom_read_en[i], busy[i]},
                 rom_address[i], rdata0[i], rdata1[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge clk);
    addr0 = 32'd2;
    req0  = 1'b1;
    push_exp(1'b0, rom_fn(32'd2), 1'b0);
    @(negedge clk);
    req0 = 1'b0;
    checks++;
    if ({gnt0[0], gnt1[0], rom_ce[0], rom_read_en[0], busy[0], rvalid0[0]} !== 6'b101110 || rom_address[0] !== 32'd2) begin
      errors++;
      $display("FAIL single_access: gnt0,gnt1,ce,re,busy,rv0=%b addr=%0d, required 101110 addr=2",
               {gnt0[0], gnt1[0], rom_ce[0], rom_read_en[0], busy[0], rvalid0[0]}, rom_address[0]);
    end
    @(negedge clk);
    checks++;
    if ({rvalid0[0], gnt0[0], rom_ce[0], rom_read_en[0], busy[0]} !== 5'b10000 || rom_address[0] !== 32'd0) begin
      errors++;
      $display("FAIL single_resp: rv0,gnt0,ce,re,busy=%b addr=%0d, required 10000 addr=0",
               {rvalid0[0], gnt0[0], rom_ce[0], rom_read_en[0], busy[0]}, rom_address[0]);
    end
    if (rvalid0[0] && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (rdata0[0] !== e.data || err0[0] !== e.err) begin
        errors++;
        $display("FAIL single_data: rdata0=%h err0=%b, required %h %b", rdata0[0], err0[0], e.data, e.err);
      end
    end
    @(negedge clk);
    checks++;
    if (rvalid0[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_rvalid_pulse: rvalid0=%b, required 0", rvalid0[0]);
    end
    sb_q.delete();
    wait_idle();
  endtask

  task automatic test_contention();
    exp_t       e;
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    do_reset();
    addr0 = 32'd2;
    addr1 = 32'd5;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(k[0], rom_fn(k[0] ? 32'd5 : 32'd2), 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_gnt = (k % 2 == 0) ? (((k / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rv  = (k % 2 == 1) ? (((k / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if ({gnt1[0], gnt0[0]} !== exp_gnt || {rvalid1[0], rvalid0[0]} !== exp_rv) begin
        errors++;
        $display("FAIL contention_cycle%0d: gnt=%b rvalid=%b, required gnt=%b rvalid=%b",
                 k, {gnt1[0], gnt0[0]}, {rvalid1[0], rvalid0[0]}, exp_gnt, exp_rv);
      end
      if ((rvalid0[0] || rvalid1[0]) && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (rvalid1[0] !== e.port || (e.port ? rdata1[0] : rdata0[0]) !== e.data) begin
          errors++;
          $display("FAIL contention_data%0d: port=%b data=%h, required port=%b data=%h",
                   k, rvalid1[0], rvalid1[0] ? rdata1[0] : rdata0[0], e.port, e.data);
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL contention_drain: %0d responses missing, required 0", sb_q.size());
    end
    sb_q.delete();
    wait_idle();
  endtask

  task automatic test_wait_cycles();
    exp_t e;
    int   ce_cnt  = 0;
    int   busy_cnt = 0;
    int   rv_at   = -1;
    @(negedge clk);
    addr1 = 32'd7;
    req1  = 1'b1;
    push_exp(1'b1, rom_fn(32'd7), 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req1 = 1'b0;
        checks++;
        if (gnt1[1] !== 1'b1) begin
          errors++;
          $display("FAIL wait_gnt1: gnt1=%b, required 1", gnt1[1]);
        end
      end
      if (rom_ce[1]) ce_cnt++;
      if (busy[1]) busy_cnt++;
      if (rom_ce[1] && rom_address[1] !== 32'd7) begin
        checks++;
        errors++;
        $display("FAIL wait_addr%0d: rom_address=%0d, required 7", k, rom_address[1]);
      end
      if (rvalid1[1] && sb_q.size() > 0) begin
        rv_at = k;
        e = sb_q.pop_front();
        checks++;
        if (rdata1[1] !== e.data) begin
          errors++;
          $display("FAIL wait_data: rdata1=%h, required %h", rdata1[1], e.data);
        end
      end
    end
    checks++;
    if (ce_cnt != 3 || busy_cnt != 3 || rv_at != 3) begin
      errors++;
      $display("FAIL wait_timing: ce=%0d busy=%0d rvalid_at=%0d, required 3 3 3", ce_cnt, busy_cnt, rv_at);
    end
    sb_q.delete();
    wait_idle();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   seen = 0;
    int   n    = 0;
    do_reset();
    addr0 = 32'd2;
    req0  = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    checks++;
    if (gnt0[2] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gnt0: gnt0=%b, required 1", gnt0[2]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt0[2], rvalid0[2], err0[2], rom_ce[2], rom_read_en[2], busy[2]} !== 6'b0 ||
        rom_address[2] !== 32'd0 || rdata0[2] !== 32'd0) begin
      errors++;
      $display("FAIL midrst_async: ctl=%b addr=%h rd0=%h, required all 0",
               {gnt0[2], rvalid0[2], err0[2], rom_ce[2], rom_read_en[2], busy[2]}, rom_address[2], rdata0[2]);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rvalid0[2] || busy[2]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_dropped: %0d active cycles after reset, required 0", seen);
    end
    addr0 = 32'd2;
    addr1 = 32'd5;
    req0  = 1'b1;
    req1  = 1'b1;
    push_exp(1'b0, rom_fn(32'd2), 1'b0);
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if ({gnt1[2], gnt0[2]} !== 2'b01) begin
      errors++;
      $display("FAIL midrst_tie: gnt=%b, required 01", {gnt1[2], gnt0[2]});
    end
    while (!rvalid0[2] && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rvalid0[2]) begin
      errors++;
      $display("FAIL midrst_regrant: rvalid0=%b after %0d cycles, required 1", rvalid0[2], n);
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (rdata0[2] !== e.data || n != 4) begin
        errors++;
        $display("FAIL midrst_data: rdata0=%h latency=%0d, required %h 4", rdata0[2], n, e.data);
      end
    end
    sb_q.delete();
    wait_idle();
  endtask

  task automatic test_bounds();
    exp_t e;
    logic exp_ce;
`ifdef ROM_ARB_BOUNDS_CHECK_EN
    exp_ce = 1'b0;
    push_exp(1'b0, 32'd0, 1'b1);
`else
    exp_ce = 1'b1;
    push_exp(1'b0, rom_fn(32'd234), 1'b0);
`endif
    push_exp(1'b0, rom_fn(32'd2), 1'b0);
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      addr0 = (t == 0) ? 32'd234 : 32'd2;
      req0  = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      checks++;
      if (busy[0] !== 1'b1 || rom_ce[0] !== ((t == 0) ? exp_ce : 1'b1) || rom_read_en[0] !== rom_ce[0]) begin
        errors++;
        $display("FAIL bounds_ce%0d: busy=%b ce=%b re=%b, required 1 %b %b", t, busy[0], rom_ce[0], rom_read_en[0],
                 (t == 0) ? exp_ce : 1'b1, (t == 0) ? exp_ce : 1'b1);
      end
`ifndef ROM_ARB_BOUNDS_CHECK_EN
      checks++;
      if (rom_address[0] !== addr0) begin
        errors++;
        $display("FAIL bounds_addr%0d: rom_address=%0d, required %0d", t, rom_address[0], addr0);
      end
`endif
      @(negedge clk);
      checks++;
      if (rvalid0[0] !== 1'b1 || sb_q.size() == 0) begin
        errors++;
        $display("FAIL bounds_rvalid%0d: rvalid0=%b, required 1", t, rvalid0[0]);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (rdata0[0] !== e.data || err0[0] !== e.err) begin
          errors++;
          $display("FAIL bounds_resp%0d: rdata0=%h err0=%b, required %h %b", t, rdata0[0], err0[0], e.data, e.err);
        end
      end
      wait_idle();
    end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wait_cycles();
    test_reset_mid();
    test_bounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Two-requester controller that shares the single instruction/constant ROM (rom_using_case: 32-bit address, 32-bit data, read_en, ce) between instruction fetch (port 0) and data load (port 1).
- Sequences each ROM access: drives ce/read_en/address for a programmable number of cycles, then registers the data and returns it with a one-cycle valid pulse.
- Arbitration between the two ports is round-robin.
- Sits between the fetch/load stages and the ROM instance.

Parameters:
- WAIT_CYCLES, 1, cycles the ROM is driven before data is sampled (legal values ≥1).
- ROM_DEPTH, 256, number of valid ROM words; used only by the optional bounds check.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req0  in  1  port 0 request; held high until gnt0 is seen
- addr0  in  32  port 0 word address; stable while req0 is high
- gnt0  out  1  one-cycle grant pulse, registered
- rvalid0  out  1  one-cycle read-data-valid pulse
- rdata0  out  32  port 0 read data; holds its value between responses
- err0  out  1  out-of-range flag, asserted together with rvalid0
- req1, addr1, gnt1, rvalid1, rdata1, err1: same as port 0, for port 1
- rom_address  out  32  to ROM address
- rom_read_en  out  1  to ROM read_en
- rom_ce  out  1  to ROM ce
- rom_data  in  32  from ROM data (combinational ROM)
- busy  out  1  high while state is ACCESS

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - gnt*, rvalid*, err*, rom_ce, rom_read_en, busy all 0.
  - rom_address, rdata0, rdata1 all 0; wait counter 0.
- State IDLE, at each rising edge:
  - If exactly one req is high, that port wins.
  - If both are high, the port != last_grant wins.
  - The winner's gnt pulses high for the next cycle; addrN is latched into rom_address; last_grant is set to the winner; counter=WAIT_CYCLES-1; state goes to ACCESS.
  - If no req is high, stay in IDLE.
- State ACCESS:
  - rom_ce=1, rom_read_en=1, rom_address holds the latched value, busy=1.
  - req inputs are ignored. The requester drops req after seeing gnt; a req still high during the gnt cycle is not re-granted.
  - At each edge with counter≠0: decrement the counter.
  - At the edge with counter==0: rom_data is registered into rdataN of the granted port; rvalidN pulses for one cycle; ce, read_en and address return to 0; state goes to IDLE.
- Latency and throughput:
  - Req sampled at edge E0 gives rvalid high after edge E0+WAIT_CYCLES.
  - Next grant occurs no earlier than edge E0+WAIT_CYCLES+1, so one access per WAIT_CYCLES+1 cycles.
- The non-granted rdata register is unchanged.
- gnt and rvalid are never high simultaneously on the same port.
- Outside ACCESS, rom_ce, rom_read_en and rom_address are all 0. The ROM never sees a stale enable.
- Reset mid-ACCESS: the transaction is dropped and no rvalid is generated. The requester must re-issue.
- No write path; addresses are word indices passed unchanged.

Optional Feature:
- Macro ROM_ARB_BOUNDS_CHECK_EN.
- Defined:
  - At grant, a latched address ≥ROM_DEPTH marks the transaction out of range.
  - During that ACCESS, rom_ce and rom_read_en stay 0.
  - The response returns rdataN=0 with errN=1 alongside rvalidN.
  - Timing is identical to a normal access.
- Undefined: no comparison; every address goes to the ROM; err0 and err1 are tied 0.

Decomposition:
- Shared package mips_pkg:
  - state encoding (IDLE=1'b0, ACCESS=1'b1)
  - WORD_W=32, ADDR_W=32
  - ROM_DEPTH_DEFAULT=256
- Sub-module rr_arb2: 2-way round-robin pick from req0, req1 and last_grant, producing a one-hot winner; combinational plus the last_grant register.

Test Plan:
- Single request: WAIT_CYCLES=1, req0=1, addr0=2 → gnt0 one cycle after the sampling edge; rom_ce, rom_read_en and rom_address=2 for 1 cycle; rvalid0 the next cycle with rdata0 equal to the ROM model word 2; rom_ce=0 afterwards.
- Contention: req0 and req1 high together (addr0=2, addr1=5) continuously → grants alternate 0,1,0,1 starting with port 0; rvalid0 and rvalid1 alternate, each with the correct word; one access per 2 cycles.
- Wait cycles: WAIT_CYCLES=3, req1 with addr1=7 → rom_ce high exactly 3 cycles; rvalid1 3 edges after the grant edge; busy high for the same 3 cycles.
- Reset mid-access: WAIT_CYCLES=4, grant port 0, assert rst in the 2nd ACCESS cycle → all outputs 0 immediately (async), no rvalid0; after release, req0 is re-granted normally and port 0 wins the first tie.
- Bounds check (macro on, ROM_DEPTH=64): addr0=234 → rom_ce stays 0; rvalid0=1, err0=1, rdata0=0. addr0=2 → err0=0 with correct data. Macro off: addr0=234 drives rom_address=234 and err0 is never 1.
